// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity modes and parity helper
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    // Narrower characters are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [8:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty/count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [AW:0]      count_next;

    // A push while full is dropped even when a pop frees a slot in the same cycle.
    always_comb begin
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a character FIFO
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_BITS-1:0]          i_char,
    input  logic                          i_write,
    input  logic [1:0]                    i_parity,
    input  logic                          i_two_stop,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    import uart_pkg::*;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [15:0]          clk_cnt;
    logic [3:0]           bit_idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] data_q;
    logic [1:0]           par_mode_q;
    logic                 par_bit_q;
    logic                 two_stop_q;

    logic [DATA_BITS-1:0] head;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 frame_done;
    logic                 par_en;
    logic                 pop;
    logic                 going_idle;
    logic                 accept;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (i_write),
        .push_data (i_char),
        .pop       (pop),
        .pop_data  (head),
        .full      (o_full),
        .empty     (fifo_empty),
        .count     (o_count)
    );

    always_comb begin
        bit_end    = (clk_cnt == BIT_LAST);
        frame_done = (state == ST_STOP) && bit_end && (stop_cnt == two_stop_q);
        par_en     = (par_mode_q == PARITY_EVEN) || (par_mode_q == PARITY_ODD);
        pop        = !fifo_empty && ((state == ST_IDLE) || frame_done);
        going_idle = fifo_empty && ((state == ST_IDLE) || frame_done);
        accept     = i_write && !o_full;
    end

    // Config is captured at pop time so mid-frame changes only affect the next character.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            data_q     <= '0;
            par_mode_q <= PARITY_NONE;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
        end else begin
            o_busy <= !going_idle || accept;
            if (pop) begin
                data_q     <= head;
                par_mode_q <= i_parity;
                par_bit_q  <= parity_of(9'(head), i_parity);
                two_stop_q <= i_two_stop;
                clk_cnt    <= '0;
                o_tx       <= 1'b0;
                state      <= ST_START;
            end else if (state == ST_IDLE) begin
                o_tx <= 1'b1;
            end else if (!bit_end) begin
                clk_cnt <= clk_cnt + 16'd1;
            end else begin
                clk_cnt <= '0;
                case (state)
                    ST_START: begin
                        o_tx    <= data_q[0];
                        data_q  <= data_q >> 1;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_idx == DATA_LAST) begin
                            stop_cnt <= 1'b0;
                            if (par_en) begin
                                o_tx  <= par_bit_q;
                                state <= ST_PARITY;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            o_tx    <= data_q[0];
                            data_q  <= data_q >> 1;
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        o_tx     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (stop_cnt != two_stop_q) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else begin
                            o_tx  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        o_tx  <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clocks per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: character width; legal range 5..9.
REQ-003 Parameter FIFO_DEPTH, default 16: transmit FIFO entries; power of two, 2..256.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_char  in  DATA_BITS  character to enqueue.
REQ-007 i_write  in  1  enqueue strobe, one character per asserted cycle.
REQ-008 i_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 i_two_stop  in  1  0 = one stop bit, 1 = two stop bits.
REQ-010 o_tx  out  1  serial line, idle high.
REQ-011 o_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
REQ-012 o_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-013 o_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Write SHALL be accepted when i_write=1 and o_full=0; a write while o_full=1 SHALL be dropped without side effect, even if a pop occurs the same cycle.
REQ-015 Simultaneous accepted write and pop SHALL leave o_count unchanged.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: o_tx=1; on a cycle with FIFO non-empty, the FSM SHALL pop the head, latch it plus i_parity and i_two_stop, drive o_tx=0 from the next edge and enter START.
REQ-018 A write accepted at edge N into an empty FIFO with FSM idle SHALL produce o_tx=0 after edge N+1.
REQ-019 Each bit (start, data, parity, stop) SHALL last exactly CLKS_PER_BIT cycles; the bit counter SHALL reload to 0 at every bit boundary.
REQ-020 DATA SHALL send DATA_BITS bits LSB first, then go to PARITY if parity is enabled, else STOP.
REQ-021 Parity bit SHALL be XOR of the data bits (even) or its inverse (odd).
REQ-022 STOP SHALL drive o_tx=1 for one or two bit times per the latched i_two_stop.
REQ-023 At end of STOP, if the FIFO is non-empty, the next start bit SHALL begin on the following cycle with no idle gap; otherwise return to IDLE.
REQ-024 Config inputs changed mid-frame SHALL NOT affect the frame in progress.
REQ-025 o_busy SHALL fall on the same edge the FSM enters IDLE with an empty FIFO.
REQ-026 Outputs SHALL be registered; o_tx SHALL never glitch.

Reset
REQ-027 While i_rst=1: o_tx=1, o_busy=0, o_full=0, o_count=0, FSM=IDLE, FIFO pointers 0.
REQ-028 Reset mid-frame SHALL abort the frame, raise o_tx on the next edge and discard FIFO contents.
REQ-029 i_write asserted in a reset cycle SHALL be ignored.

Structure
REQ-030 Shared package uart_pkg SHALL hold FSM state encodings and parity-mode constants (PARITY_NONE/EVEN/ODD), for reuse by a future uart_rx.
REQ-031 Storage SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4)
REQ-032 Write 0x55, parity none, one stop -> o_tx low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; o_busy falls after 40 cycles of frame.
REQ-033 Write 0x07, even parity, two stop -> parity bit 1, stop high 8 cycles; odd parity -> parity bit 0.
REQ-034 Burst 5 writes 0x01..0x05 in consecutive cycles -> first pops immediately, remaining 4 queued, o_full=1, none dropped; all 5 frames back-to-back, no idle cycle between stop and next start.
REQ-035 Fill FIFO to 4 while transmitting, write 0xAA while full -> 0xAA dropped, o_count stays 4.
REQ-036 Assert i_rst during third data bit of 0xF0 with 2 queued -> o_tx=1 next edge, o_count=0, o_busy=0, no further frames.
REQ-037 Toggle i_parity mid-frame -> current frame uses old setting, next frame uses new.
